// File: rtl/vip_matrix_pkg.sv
// ----------------------------------------------------------------------------
// vip_matrix_pkg
//   Shared constants, FSM state type and window index helper for the 5x5
//   matrix window generator.
//   Contents:
//     DATA_W_DEF  default pixel width
//     RAM_LAT_DEF default line-buffer latency (ram_clken -> ram_post_clken)
//     WIN         window edge length (5)
//     state_e     IDLE / ACTIVE
//     win_idx     flat element index of p[r][c] inside matrix_p
// ----------------------------------------------------------------------------
package vip_matrix_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned RAM_LAT_DEF = 3;
    localparam int unsigned WIN         = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
        return WIN * r + c;
    endfunction

endpackage

// File: rtl/vip_win_row_shift.sv
// ----------------------------------------------------------------------------
// vip_win_row_shift
//   One row of the 5x5 window: a 5-stage DATA_W shift register. Column c0 is
//   the oldest pixel, c4 the newest; a shift moves c0<=c1 .. c3<=c4, c4<=din.
//   A synchronous clear zeroes c0..c3; if a shift happens in the same clock,
//   c4 still takes din so the first pixel of a line is not lost.
//   Ports:
//     clk    in   clock
//     rst_n  in   asynchronous reset, active low
//     i_en   in   shift enable
//     i_clr  in   synchronous clear
//     i_din  in   DATA_W pixel shifted into c4
//     o_row  out  5*DATA_W row; c at [DATA_W*c +: DATA_W]
// ----------------------------------------------------------------------------
module vip_win_row_shift
    import vip_matrix_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic [DATA_W-1:0]     i_din,
    output logic [WIN*DATA_W-1:0] o_row
);

    logic [DATA_W-1:0] r_col [WIN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN; i++) begin
                r_col[i] <= '0;
            end
        end else if (i_clr) begin
            for (int i = 0; i < WIN - 1; i++) begin
                r_col[i] <= '0;
            end
            r_col[WIN-1] <= i_en ? i_din : '0;
        end else if (i_en) begin
            for (int i = 0; i < WIN - 1; i++) begin
                r_col[i] <= r_col[i+1];
            end
            r_col[WIN-1] <= i_din;
        end
    end

    always_comb begin
        o_row = '0;
        for (int i = 0; i < WIN; i++) begin
            o_row[DATA_W*i +: DATA_W] = r_col[i];
        end
    end

endmodule

// File: rtl/vip_matrix_window_5x5.sv
// ----------------------------------------------------------------------------
// vip_matrix_window_5x5
//   Consumer end of the 5x5 line-shift RAM interface. Feeds the line buffer
//   with the live pixel stream, takes back its four previous-row taps and
//   assembles a registered 5x5 window; vsync/href are re-timed to match.
//   Optional build macro: MATRIX_ROW_ZERO_EN -- rows not yet filled in the
//   current frame are forced to 0 instead of passing stale RAM content.
//   Ports:
//     clk                 in   clock
//     rst_n               in   asynchronous reset, active low
//     i_per_frame_vsync   in   frame sync
//     i_per_frame_href    in   line valid
//     i_per_frame_clken   in   pixel strobe
//     i_per_img_y         in   pixel
//     o_ram_clken         out  strobe to line buffer
//     o_ram_shiftin       out  pixel to line buffer
//     i_ram_post_clken    in   line-buffer output strobe
//     i_ram_taps0x..3x    in   rows n-1..n-4
//     o_post_frame_vsync  out  vsync delayed RAM_LAT+1
//     o_post_frame_href   out  href delayed RAM_LAT+1 (0 while IDLE)
//     o_post_frame_clken  out  window strobe
//     o_matrix_p          out  window, p[r][c] at DATA_W*(5r+c)
//     o_matrix_valid      out  window holds 25 real pixels of this frame
// ----------------------------------------------------------------------------
module vip_matrix_window_5x5
    import vip_matrix_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned RAM_LAT = RAM_LAT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_per_frame_vsync,
    input  logic                      i_per_frame_href,
    input  logic                      i_per_frame_clken,
    input  logic [DATA_W-1:0]         i_per_img_y,
    output logic                      o_ram_clken,
    output logic [DATA_W-1:0]         o_ram_shiftin,
    input  logic                      i_ram_post_clken,
    input  logic [DATA_W-1:0]         i_ram_taps0x,
    input  logic [DATA_W-1:0]         i_ram_taps1x,
    input  logic [DATA_W-1:0]         i_ram_taps2x,
    input  logic [DATA_W-1:0]         i_ram_taps3x,
    output logic                      o_post_frame_vsync,
    output logic                      o_post_frame_href,
    output logic                      o_post_frame_clken,
    output logic [WIN*WIN*DATA_W-1:0] o_matrix_p,
    output logic                      o_matrix_valid
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [RAM_LAT:0]  r_vs_dly;
    logic [RAM_LAT:0]  r_hs_dly;
    logic [DATA_W-1:0] r_pix_dly [RAM_LAT];
    logic [2:0]        r_col_cnt;
    logic [2:0]        r_row_cnt;
    logic [2:0]        w_col_now;
    logic [2:0]        w_col_nxt;
    logic [2:0]        w_row_nxt;
    logic              r_post_clken;
    logic              r_matrix_valid;
    logic              w_active;
    logic              w_vs_rise;
    logic              w_hs_lat;
    logic              w_hs_rise;
    logic              w_hs_fall;
    logic              w_strobe;
    logic              w_shift;
    logic [DATA_W-1:0] w_row_in [WIN];

    assign w_active  = (r_state == ACTIVE);
    assign w_vs_rise = i_per_frame_vsync & ~r_vs_dly[0];
    // href delayed RAM_LAT: lines up with ram_post_clken and the taps, so the
    // line-start clear lands on the same edge as the first shift of the line.
    assign w_hs_lat  = r_hs_dly[RAM_LAT-1];
    assign w_hs_rise = w_hs_lat & ~r_hs_dly[RAM_LAT];
    assign w_hs_fall = ~w_hs_lat & r_hs_dly[RAM_LAT];
    assign w_strobe  = i_ram_post_clken & w_hs_lat;
    assign w_shift   = w_strobe & w_active;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and line-buffer drive
    always_comb begin
        w_state_nxt        = r_state;
        o_ram_clken        = 1'b0;
        o_ram_shiftin      = '0;
        o_post_frame_href  = 1'b0;
        o_post_frame_vsync = r_vs_dly[RAM_LAT];
        if (w_vs_rise) begin
            w_state_nxt = ACTIVE;
        end
        if (w_active) begin
            o_ram_clken       = i_per_frame_clken;
            o_ram_shiftin     = i_per_img_y;
            o_post_frame_href = r_hs_dly[RAM_LAT];
        end
    end

    // Sync delay lines and current-row pixel delay, unconditional every clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_dly <= '0;
            r_hs_dly <= '0;
            for (int i = 0; i < RAM_LAT; i++) begin
                r_pix_dly[i] <= '0;
            end
        end else begin
            r_vs_dly     <= {r_vs_dly[RAM_LAT-1:0], i_per_frame_vsync};
            r_hs_dly     <= {r_hs_dly[RAM_LAT-1:0], i_per_frame_href};
            r_pix_dly[0] <= i_per_img_y;
            for (int i = 1; i < RAM_LAT; i++) begin
                r_pix_dly[i] <= r_pix_dly[i-1];
            end
        end
    end

    // Column/row fill counters, both saturating at 4
    always_comb begin
        w_col_now = w_hs_rise ? 3'd0 : r_col_cnt;
        w_col_nxt = w_col_now;
        if (w_strobe && (w_col_now != 3'd4)) begin
            w_col_nxt = w_col_now + 3'd1;
        end
        w_row_nxt = r_row_cnt;
        // vsync clear beats a coincident line-end increment
        if (w_vs_rise) begin
            w_row_nxt = 3'd0;
        end else if (w_hs_fall && (r_row_cnt != 3'd4)) begin
            w_row_nxt = r_row_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_cnt      <= '0;
            r_row_cnt      <= '0;
            r_post_clken   <= 1'b0;
            r_matrix_valid <= 1'b0;
        end else begin
            r_col_cnt      <= w_col_nxt;
            r_row_cnt      <= w_row_nxt;
            r_post_clken   <= w_shift;
            r_matrix_valid <= w_shift && (r_row_cnt == 3'd4) && (w_col_now == 3'd4);
        end
    end

    assign o_post_frame_clken = r_post_clken;
    assign o_matrix_valid     = r_matrix_valid;

    // Row sources: r0 = oldest line (taps3x) .. r4 = current line
    always_comb begin
        w_row_in[0] = i_ram_taps3x;
        w_row_in[1] = i_ram_taps2x;
        w_row_in[2] = i_ram_taps1x;
        w_row_in[3] = i_ram_taps0x;
        w_row_in[4] = r_pix_dly[RAM_LAT-1];
`ifdef MATRIX_ROW_ZERO_EN
        // Row r holds a line of this frame only once row_cnt >= 4-r
        for (int r = 0; r < WIN - 1; r++) begin
            if (int'(r_row_cnt) < (WIN - 1 - r)) begin
                w_row_in[r] = '0;
            end
        end
`endif
    end

    for (genvar r = 0; r < WIN; r++) begin : g_row
        vip_win_row_shift #(
            .DATA_W (DATA_W)
        ) u_row (
            .clk   (clk),
            .rst_n (rst_n),
            .i_en  (w_shift),
            .i_clr (w_hs_rise),
            .i_din (w_row_in[r]),
            .o_row (o_matrix_p[DATA_W*win_idx(r, 0) +: WIN*DATA_W])
        );
    end

endmodule
